// File: rtl/bram_read_arbiter.sv
// bram_read_arbiter: shares one BRAM read port between several requesters.
// Round-robin arbitration with an optional locked burst mode, a tag pipeline
// that routes read data back to the requester that issued the address, and
// a watchdog that breaks a lock held by an owner that has gone quiet.
`timescale 1ns/1ps

module bram_read_arbiter #(
  parameter int BIT_WIDTH   = 32,
  parameter int I           = 160,
  parameter int REQUESTERS  = 3,
  parameter int LATENCY     = 2,
  parameter int MAX_BURST   = 8,
  parameter int I_WIDTH     = $clog2(I),
  parameter int OWNER_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n_in,
  input  logic [REQUESTERS-1:0]                req_valid,
  input  logic [REQUESTERS-1:0][I_WIDTH-1:0]   req_addr,
  input  logic [REQUESTERS-1:0]                req_lock,
  output logic [REQUESTERS-1:0]                req_ready,
  output logic [I_WIDTH-1:0]                   bram_addr,
  input  logic [BIT_WIDTH-1:0]                 bram_dout,
  output logic [REQUESTERS-1:0]                resp_valid,
  output logic [BIT_WIDTH-1:0]                 resp_data,
  output logic [OWNER_WIDTH-1:0]               owner,
  output logic                                 locked
);

  localparam int BURST_WIDTH = $clog2(MAX_BURST + 1);
  localparam int WD_LIMIT    = 4 * MAX_BURST;
  localparam int WD_WIDTH    = $clog2(WD_LIMIT + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                              state, state_next;
  logic [OWNER_WIDTH-1:0]              rr_ptr, rr_ptr_next;
  logic [OWNER_WIDTH-1:0]              owner_next;
  logic [BURST_WIDTH-1:0]              burst_cnt, burst_cnt_next;
  logic [WD_WIDTH-1:0]                 watchdog, watchdog_next;
  logic [1:0]                          rst_sync;
  logic                                run;
  logic                                grant_any;
  logic [OWNER_WIDTH-1:0]              grant_idx;
  logic [I_WIDTH-1:0]                  addr_q;
  logic [LATENCY-1:0]                  tag_valid;
  logic [LATENCY-1:0][OWNER_WIDTH-1:0] tag_idx;

  // Requester indices wrap modulo the requester count.
  function automatic logic [OWNER_WIDTH-1:0] wrap_idx(input int value);
    return OWNER_WIDTH'(value % REQUESTERS);
  endfunction

  // Reset release is brought into the clock domain; grants stay off until
  // the synchronised release has propagated.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = rst_sync[1];

  // Pick the single requester to grant this cycle: only the owner while a
  // lock is held, otherwise the first valid requester starting at rr_ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    if (run) begin
      if (state == OWNED) begin
        if (req_valid[owner]) begin
          grant_any = 1'b1;
          grant_idx = owner;
        end
      end else begin
        for (int k = 0; k < REQUESTERS; k++) begin
          if (!grant_any && req_valid[wrap_idx(int'(rr_ptr) + k)]) begin
            grant_any = 1'b1;
            grant_idx = wrap_idx(int'(rr_ptr) + k);
          end
        end
      end
    end
  end

  // One-hot ready for the chosen requester.
  always_comb begin
    req_ready = '0;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign bram_addr = grant_any ? req_addr[grant_idx] : addr_q;
  assign locked    = (state == OWNED);

  // Next-state logic for the lock FSM, round-robin pointer, burst length
  // and idle-owner watchdog.
  always_comb begin
    state_next     = state;
    rr_ptr_next    = rr_ptr;
    owner_next     = owner;
    burst_cnt_next = burst_cnt;
    watchdog_next  = watchdog;
    case (state)
      IDLE: begin
        if (grant_any) begin
          rr_ptr_next = wrap_idx(int'(grant_idx) + 1);
          if (req_lock[grant_idx] && (MAX_BURST > 1)) begin
            state_next     = OWNED;
            owner_next     = grant_idx;
            burst_cnt_next = BURST_WIDTH'(1);
            watchdog_next  = '0;
          end
        end
      end
      OWNED: begin
        if (grant_any) begin
          burst_cnt_next = burst_cnt + 1'b1;
          watchdog_next  = '0;
          if (!req_lock[owner] || (int'(burst_cnt) + 1 >= MAX_BURST)) begin
            state_next  = IDLE;
            rr_ptr_next = wrap_idx(int'(owner) + 1);
          end
        end else begin
          watchdog_next = watchdog + 1'b1;
          if (int'(watchdog) + 1 >= WD_LIMIT) begin
            state_next    = IDLE;
            rr_ptr_next   = wrap_idx(int'(owner) + 1);
            watchdog_next = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Arbitration state registers and the held BRAM address.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      watchdog  <= '0;
      addr_q    <= '0;
    end else begin
      state     <= state_next;
      rr_ptr    <= rr_ptr_next;
      owner     <= owner_next;
      burst_cnt <= burst_cnt_next;
      watchdog  <= watchdog_next;
      addr_q    <= bram_addr;
    end
  end

  // Tag pipeline matching the BRAM latency; in-flight tags keep moving
  // regardless of what the arbitration FSM does afterwards.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tag_valid <= '0;
      tag_idx   <= '0;
    end else begin
      tag_valid[0] <= grant_any;
      tag_idx[0]   <= grant_idx;
      for (int s = 1; s < LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_idx[s]   <= tag_idx[s-1];
      end
    end
  end

  // Route returning BRAM data to the requester named by the oldest tag.
  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    if (tag_valid[LATENCY-1]) begin
      resp_valid[tag_idx[LATENCY-1]] = 1'b1;
      resp_data                      = bram_dout;
    end
  end

endmodule
